// File: rtl/ap_ctrl_driver.sv
// Initiator for the ap_ctrl_chain handshake: issues N starts, acks dones, raises finish.
// Latency: ap_start one edge after accepted go; finish one edge after the final done/continue.
// Backpressure: starts throttled to MAX_OUTSTANDING in flight; cont_stall holds ap_continue low.
module ap_ctrl_driver #(
    parameter int COUNT_WIDTH     = 16,
    parameter int TIMEOUT_WIDTH   = 20,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     go,
    input  logic [COUNT_WIDTH-1:0]   cfg_num_tx,
    input  logic [TIMEOUT_WIDTH-1:0] cfg_timeout,
    input  logic                     cont_stall,
    output logic                     ap_start,
    input  logic                     ap_ready,
    input  logic                     ap_done,
    input  logic                     ap_idle,
    output logic                     ap_continue,
    output logic                     busy,
    output logic                     finish,
    output logic                     timeout,
    output logic                     proto_err,
    output logic [COUNT_WIDTH-1:0]   issued_cnt,
    output logic [COUNT_WIDTH-1:0]   done_cnt
);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

    localparam logic [COUNT_WIDTH-1:0] MAX_OUT = COUNT_WIDTH'(MAX_OUTSTANDING);

    state_t                   state_q, state_d;
    logic [COUNT_WIDTH-1:0]   issued_q, issued_d;
    logic [COUNT_WIDTH-1:0]   done_q, done_d;
    logic [COUNT_WIDTH-1:0]   num_q, num_d;
    logic [COUNT_WIDTH-1:0]   outstanding_q, outstanding_d;
    logic [TIMEOUT_WIDTH-1:0] to_q, to_d;
    logic [TIMEOUT_WIDTH-1:0] wd_q, wd_d;
    logic                     start_q, start_d;
    logic                     cont_q, cont_d;
    logic                     timeout_q, timeout_d;
    logic                     perr_q, perr_d;
    logic                     idle_low_q, idle_low_d;
    logic                     busy_q, finish_q;
    logic                     issue, complete;

    assign issue         = start_q & ap_ready;
    assign complete      = ap_done & cont_q;
    assign outstanding_q = issued_q - done_q;

    always_comb begin
        state_d    = state_q;
        issued_d   = issued_q;
        done_d     = done_q;
        num_d      = num_q;
        to_d       = to_q;
        wd_d       = wd_q;
        timeout_d  = timeout_q;
        perr_d     = perr_q;
        idle_low_d = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (go) begin
                    num_d     = cfg_num_tx;
                    to_d      = cfg_timeout;
                    issued_d  = '0;
                    done_d    = '0;
                    wd_d      = '0;
                    timeout_d = 1'b0;
                    perr_d    = 1'b0;
                    state_d   = (cfg_num_tx == '0) ? ST_DONE : ST_RUN;
                end else if (state_q == ST_DONE && !timeout_q && !ap_idle) begin
                    // Module must settle to idle within one cycle of a clean finish
                    idle_low_d = 1'b1;
                    if (idle_low_q) perr_d = 1'b1;
                end
            end
            ST_RUN: begin
                if (issue)    issued_d = issued_q + 1'b1;
                if (complete) done_d   = done_q + 1'b1;
                if ((ap_done && outstanding_q == '0) || (ap_ready && !start_q))
                    perr_d = 1'b1;
                if (issue || complete)  wd_d = '0;
                else if (wd_q != '1)    wd_d = wd_q + 1'b1;
                if (done_d == num_q) begin
                    state_d = ST_DONE;
                end else if (to_q != '0 && wd_d >= to_q) begin
                    state_d   = ST_DONE;
                    timeout_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        outstanding_d = issued_d - done_d;
        start_d = (state_d == ST_RUN) && (issued_d < num_d) && (outstanding_d < MAX_OUT);
        cont_d  = (state_d == ST_RUN) && !cont_stall;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            issued_q   <= '0;
            done_q     <= '0;
            num_q      <= '0;
            to_q       <= '0;
            wd_q       <= '0;
            start_q    <= 1'b0;
            cont_q     <= 1'b0;
            timeout_q  <= 1'b0;
            perr_q     <= 1'b0;
            idle_low_q <= 1'b0;
            busy_q     <= 1'b0;
            finish_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            issued_q   <= issued_d;
            done_q     <= done_d;
            num_q      <= num_d;
            to_q       <= to_d;
            wd_q       <= wd_d;
            start_q    <= start_d;
            cont_q     <= cont_d;
            timeout_q  <= timeout_d;
            perr_q     <= perr_d;
            idle_low_q <= idle_low_d;
            busy_q     <= (state_d == ST_RUN);
            finish_q   <= (state_d == ST_DONE);
        end
    end

    assign ap_start    = start_q;
    assign ap_continue = cont_q;
    assign busy        = busy_q;
    assign finish      = finish_q;
    assign timeout     = timeout_q;
    assign proto_err   = perr_q;
    assign issued_cnt  = issued_q;
    assign done_cnt    = done_q;

endmodule

// File: tb/tb_ap_ctrl_driver.sv
// Directed bench for ap_ctrl_driver with a small responder model for the pipelined run.
module tb_ap_ctrl_driver;

    logic        clock = 1'b0;
    logic        reset, go, cont_stall, ap_ready, ap_done, ap_idle;
    logic [15:0] cfg_num_tx;
    logic [19:0] cfg_timeout;
    logic        ap_start, ap_continue, busy, finish, timeout, proto_err;
    logic [15:0] issued_cnt, done_cnt;

    int checks = 0;
    int passed = 0;

    always #5 clock = ~clock;

    ap_ctrl_driver #(.COUNT_WIDTH(16), .TIMEOUT_WIDTH(20), .MAX_OUTSTANDING(2)) dut (
        .clock(clock), .reset(reset), .go(go), .cfg_num_tx(cfg_num_tx),
        .cfg_timeout(cfg_timeout), .cont_stall(cont_stall), .ap_start(ap_start),
        .ap_ready(ap_ready), .ap_done(ap_done), .ap_idle(ap_idle),
        .ap_continue(ap_continue), .busy(busy), .finish(finish), .timeout(timeout),
        .proto_err(proto_err), .issued_cnt(issued_cnt), .done_cnt(done_cnt)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_outs"}, {ap_start, ap_continue, busy, finish, timeout, proto_err}, 0);
        chk({tag, "_issued"}, issued_cnt, 0);
        chk({tag, "_done"}, done_cnt, 0);
    endtask

    task automatic launch(input logic [15:0] n, input logic [19:0] to);
        cfg_num_tx  = n;
        cfg_timeout = to;
        go          = 1'b1;
        tick();
        go          = 1'b0;
    endtask

    initial begin
        int due[$];
        int ei, ed, iss_cyc, done_cyc;
        logic iss, cmp;

        reset = 1'b1; go = 1'b0; cont_stall = 1'b0; ap_ready = 1'b0;
        ap_done = 1'b0; ap_idle = 1'b1; cfg_num_tx = '0; cfg_timeout = '0;
        tick(); tick();
        chk_all_zero("reset");
        reset = 1'b0;

        // Single transaction, ready in the start cycle, done five cycles later
        launch(16'd1, 20'd0);
        chk("single_start_rise", {ap_start, busy, finish}, 3'b110);
        ap_ready = 1'b1;
        tick();
        ap_ready = 1'b0;
        chk("single_issued", issued_cnt, 1);
        chk("single_start_fall", ap_start, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("single_wait", {ap_start, finish, done_cnt}, 0);
        end
        ap_done = 1'b1;
        chk("single_cont", ap_continue, 1);
        tick();
        ap_done = 1'b0;
        chk("single_done", done_cnt, 1);
        chk("single_finish", {finish, busy, ap_start, ap_continue, proto_err}, 5'b10000);

        // ap_idle low for two DONE cycles after a clean finish
        ap_idle = 1'b0;
        tick();
        chk("idle_low_1", proto_err, 0);
        tick();
        chk("idle_low_2", proto_err, 1);
        ap_idle = 1'b1;

        // Pipelined run: N=4, ready always high, done latency 3
        ei = 0; ed = 0; iss_cyc = -1; done_cyc = -1;
        launch(16'd4, 20'd0);
        ap_ready = 1'b1;
        for (int c = 0; c < 40 && !finish; c++) begin
            ap_done = (due.size() > 0) && (due[0] <= c);
            iss = ap_start & ap_ready;
            cmp = ap_done & ap_continue;
            tick();
            if (iss) begin due.push_back(c + 3); ei++; end
            if (cmp) begin void'(due.pop_front()); ed++; end
            chk("pipe_issued", issued_cnt, ei);
            chk("pipe_done", done_cnt, ed);
            chk("pipe_outstanding_le2", (issued_cnt - done_cnt) <= 16'd2, 1);
            if (ei == 4 && iss_cyc < 0)  iss_cyc = c;
            if (ed == 4 && done_cyc < 0) done_cyc = c;
        end
        ap_ready = 1'b0; ap_done = 1'b0;
        chk("pipe_finish", {finish, busy}, 2'b10);
        chk("pipe_done_final", done_cnt, 4);
        chk("pipe_issue_before_done", (iss_cyc >= 0) && (iss_cyc < done_cyc), 1);

        // Back-pressure: continue held low for 10 cycles with done pending
        launch(16'd1, 20'd0);
        chk("bp_perr_cleared", proto_err, 0);
        ap_ready = 1'b1; cont_stall = 1'b1;
        tick();
        ap_ready = 1'b0; ap_done = 1'b1;
        chk("bp_issued", issued_cnt, 1);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_stall_hold", {done_cnt, ap_continue, finish}, 0);
        end
        cont_stall = 1'b0;
        tick();
        chk("bp_release_cont", {ap_continue, done_cnt}, {1'b1, 16'd0});
        tick();
        ap_done = 1'b0;
        chk("bp_done", done_cnt, 1);
        chk("bp_finish", {finish, busy}, 2'b10);

        // Watchdog: ready never arrives, timeout of 8
        launch(16'd3, 20'd8);
        chk("wd_start", ap_start, 1);
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("wd_wait", {finish, timeout, ap_start}, 3'b001);
        end
        tick();
        chk("wd_fire", {timeout, finish, busy, ap_start}, 4'b1100);
        chk("wd_issued", issued_cnt, 0);

        // N=0 goes straight to DONE and never starts
        launch(16'd0, 20'd0);
        chk("n0_finish", {finish, busy, ap_start, timeout}, 4'b1000);
        tick();
        chk("n0_no_start", {ap_start, issued_cnt}, 0);

        // Spurious done with nothing outstanding
        launch(16'd2, 20'd0);
        ap_done = 1'b1;
        tick();
        ap_done = 1'b0;
        chk("spurious_perr", proto_err, 1);
        chk("spurious_busy", busy, 1);

        // Reset in the middle of a run
        reset = 1'b1;
        tick();
        chk_all_zero("mid_reset");
        reset = 1'b0;

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
